// File: rtl/enemy_hit_to_mosquito_router_if.sv
// Hit-event handshake from the collision engine to the mosquito router.
// master: collision engine side, slave: router side.
interface enemy_hit_to_mosquito_router_if;
  logic       hit_valid;
  logic [4:0] hit_idx;
  logic       hit_ready;

  modport master (output hit_valid, output hit_idx, input hit_ready);
  modport slave  (input hit_valid, input hit_idx, output hit_ready);
endinterface

// File: rtl/enemy_hit_to_mosquito_router.sv
// Mosquito hit router: claims collision hits on the mosquito slots, buffers
// them in a small FIFO and runs a per-mosquito HP / invulnerability / death /
// respawn state machine.
// Optional build macro MOSQ_HIT_FLASH_EN: blink a hurt mosquito every 2 frames.
//
// state    | meaning
// ST_ALIVE | vulnerable, hp 1..MAX_HP, hits are applied
// ST_HURT  | invulnerable after a non-lethal hit, hits discarded, timer runs
// ST_DEAD  | killed, hp 0, hits discarded, respawn timer runs
module enemy_hit_to_mosquito_router #(
  parameter int BASE_IDX       = 21,
  parameter int NUM_MOSQ       = 2,
  parameter int MAX_HP         = 3,
  parameter int INVULN_FRAMES  = 30,
  parameter int RESPAWN_FRAMES = 120,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  enemy_hit_to_mosquito_router_if.slave hit,
  output logic [NUM_MOSQ-1:0]     mosquito_alive,
  output logic [NUM_MOSQ-1:0]     mosquito_visible,
  output logic [2*NUM_MOSQ-1:0]   mosquito_hp,
  output logic [NUM_MOSQ-1:0]     kill_pulse,
  output logic [NUM_MOSQ-1:0]     respawn_pulse,
  output logic [7:0]              drop_count
);

  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_HURT  = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  localparam int LW = (NUM_MOSQ > 1) ? $clog2(NUM_MOSQ) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [7:0] INV_T  = 8'(INVULN_FRAMES);
  localparam logic [7:0] RESP_T = 8'(RESPAWN_FRAMES);
  localparam logic [1:0] HP_MAX = 2'(MAX_HP);

  logic [LW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty;
  logic          in_range, push, pop;
  logic [LW-1:0] push_idx, pop_idx;

  // Held low in normal operation; a debug hook to stall the FIFO drain.
  logic          pop_hold;
  assign pop_hold = 1'b0;

  logic [1:0]    st    [NUM_MOSQ];
  logic [1:0]    hp    [NUM_MOSQ];
  logic [7:0]    timer [NUM_MOSQ];
  logic [NUM_MOSQ-1:0] hit_k;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign hit.hit_ready = !fifo_full;

  assign in_range = (hit.hit_idx >= 5'(BASE_IDX)) &&
                    ({1'b0, hit.hit_idx} < 6'(BASE_IDX + NUM_MOSQ));
  assign push_idx = LW'(hit.hit_idx - 5'(BASE_IDX));
  assign push     = hit.hit_valid && hit.hit_ready && in_range;
  assign pop      = !fifo_empty && !pop_hold;
  assign pop_idx  = mem[rd_ptr];

  // Decode the popped event to a per-mosquito hit strobe and pack outputs.
  always_comb begin
    hit_k          = '0;
    mosquito_alive = '0;
    mosquito_hp    = '0;
    for (int k = 0; k < NUM_MOSQ; k++) begin
      hit_k[k]            = pop && (pop_idx == LW'(k));
      mosquito_alive[k]   = (st[k] != ST_DEAD);
      mosquito_hp[2*k +: 2] = hp[k];
    end
  end

  // Hit-event FIFO: one push and one pop per cycle, occupancy tracked by count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_idx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Count mosquito hits refused because the FIFO was full, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (hit.hit_valid && !hit.hit_ready && in_range &&
                 drop_count != 8'hFF) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  // Per-mosquito state machine; all decisions use the pre-edge state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kill_pulse    <= '0;
      respawn_pulse <= '0;
      for (int k = 0; k < NUM_MOSQ; k++) begin
        st[k]    <= ST_ALIVE;
        hp[k]    <= HP_MAX;
        timer[k] <= '0;
      end
    end else begin
      kill_pulse    <= '0;
      respawn_pulse <= '0;
      for (int k = 0; k < NUM_MOSQ; k++) begin
        case (st[k])
          ST_ALIVE: begin
            if (hit_k[k]) begin
              if (hp[k] > 2'd1) begin
                hp[k]    <= hp[k] - 2'd1;
                st[k]    <= ST_HURT;
                timer[k] <= INV_T;
              end else begin
                hp[k]         <= 2'd0;
                st[k]         <= ST_DEAD;
                timer[k]      <= RESP_T;
                kill_pulse[k] <= 1'b1;
              end
            end
          end
          ST_HURT: begin
            if (frame_tick) begin
              if (timer[k] <= 8'd1) begin
                timer[k] <= '0;
                st[k]    <= ST_ALIVE;
              end else begin
                timer[k] <= timer[k] - 8'd1;
              end
            end
          end
          ST_DEAD: begin
            if (frame_tick) begin
              if (timer[k] <= 8'd1) begin
                timer[k]         <= '0;
                st[k]            <= ST_ALIVE;
                hp[k]            <= HP_MAX;
                respawn_pulse[k] <= 1'b1;
              end else begin
                timer[k] <= timer[k] - 8'd1;
              end
            end
          end
          default: st[k] <= ST_ALIVE;
        endcase
      end
    end
  end

`ifdef MOSQ_HIT_FLASH_EN
  logic [1:0] flash_cnt [NUM_MOSQ];

  // Flash phase counter, restarted each time a mosquito becomes hurt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_MOSQ; k++) flash_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_MOSQ; k++) begin
        if (st[k] == ST_ALIVE && hit_k[k] && hp[k] > 2'd1)
          flash_cnt[k] <= '0;
        else if (frame_tick)
          flash_cnt[k] <= flash_cnt[k] + 2'd1;
      end
    end
  end

  // Hurt mosquitoes blink; otherwise visibility follows alive.
  always_comb begin
    mosquito_visible = '0;
    for (int k = 0; k < NUM_MOSQ; k++)
      mosquito_visible[k] = (st[k] == ST_HURT) ? ~flash_cnt[k][1]
                                               : mosquito_alive[k];
  end
`else
  assign mosquito_visible = mosquito_alive;
`endif

endmodule
